// File: rtl/pwm_multi_channel_block.sv
// Multi-channel PWM generator on the USI slave bus: shared period counter, per-channel duty/polarity.
// Latency: CSR write lands on the strobe edge; readback, oPwm and oPwmSync are 1 cycle behind their source.
// Backpressure: none; every write strobe is accepted and reads always complete in one cycle.
module pwm_multi_channel_block #(
    parameter int pBlockAdrsMap = 8,
    parameter int pAdrsMap      = 2,
    parameter int pBusAdrsBit   = 15,
    parameter int pChNum        = 4,
    parameter int pCntWidth     = 16
) (
    input  logic              iSysClk,
    input  logic              iSysRst,
    input  logic [31:0]       iSUsiWd,
    input  logic [15:0]       iSUsiAdrs,
    input  logic              iSUsiWCke,
    output logic [31:0]       oSUsiRd,
    output logic              oSUsiVd,
    output logic [pChNum-1:0] oPwm,
    output logic              oPwmSync
);

    localparam int SelW = pBusAdrsBit - pBlockAdrsMap + 1;
    typedef logic [pCntWidth-1:0] cnt_t;

    logic              blk_hit;
    logic              wr_en;
    logic [7:0]        reg_off;
    logic              load;
    logic              unused_bus;

    logic              en_q, en_d;
    logic              mode_q, mode_d;
    logic [pChNum-1:0] pol_q, pol_d;
    cnt_t              per_sh_q, per_sh_d;
    cnt_t              per_act_q, per_act_d;
    cnt_t              duty_sh_q [pChNum];
    cnt_t              duty_sh_d [pChNum];
    cnt_t              duty_act_q [pChNum];
    cnt_t              duty_act_d [pChNum];
    cnt_t              cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [pChNum-1:0] pwm_q, pwm_d;
    logic              sync_q, sync_d;
    logic [31:0]       rd_dat_q, rd_dat_d;
    logic              rd_vld_q, rd_vld_d;

    // Upper write-data bits beyond the counter width are don't-care.
    assign unused_bus = ^{iSUsiWd, iSUsiAdrs};

    // Block select and register offset decode.
    always_comb begin
        blk_hit = (iSUsiAdrs[pBusAdrsBit:pBlockAdrsMap] == SelW'(pAdrsMap));
        reg_off = iSUsiAdrs[7:0];
        wr_en   = iSUsiWCke && blk_hit;
    end

    // CSR writes: CTRL is live immediately, PERIOD/DUTY only touch the shadows.
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        per_sh_d = per_sh_q;
        for (int n = 0; n < pChNum; n++) begin
            duty_sh_d[n] = duty_sh_q[n];
        end
        if (wr_en) begin
            if (reg_off == 8'h00) begin
                en_d   = iSUsiWd[0];
                mode_d = iSUsiWd[1];
                pol_d  = iSUsiWd[8 +: pChNum];
            end
            if (reg_off == 8'h04) begin
                per_sh_d = iSUsiWd[pCntWidth-1:0];
            end
            for (int n = 0; n < pChNum; n++) begin
                if (reg_off == 8'(8 + 4 * n)) begin
                    duty_sh_d[n] = iSUsiWd[pCntWidth-1:0];
                end
            end
        end
    end

    // Period counter: disable, enable edge or a MODE change all park it at 0 counting up.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!(en_q && en_d) || (mode_d != mode_q)) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (!mode_q) begin
            dir_d = 1'b0;
            cnt_d = (cnt_q >= per_act_q) ? '0 : cnt_q + cnt_t'(1);
        end else if (!dir_q) begin
            if (cnt_q >= per_act_q) begin
                // PERIOD 0/1 have no down leg; fold straight back to 0.
                if (per_act_q <= cnt_t'(1)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = per_act_q - cnt_t'(1);
                    dir_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end else begin
            if (cnt_q <= cnt_t'(1)) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end else begin
                cnt_d = cnt_q - cnt_t'(1);
            end
        end
    end

    // Shadow-to-active copy whenever the counter enters 0, so the counter-0 cycle
    // (the one that raises oPwmSync) already compares against the new values.
    always_comb begin
        load      = !en_q || (cnt_d == '0);
        per_act_d = load ? per_sh_q : per_act_q;
        for (int n = 0; n < pChNum; n++) begin
            duty_act_d[n] = load ? duty_sh_q[n] : duty_act_q[n];
        end
    end

    // Per-channel compare and sync pulse; disabled channels sit at their inactive level.
    always_comb begin
        pwm_d = pol_q;
        for (int n = 0; n < pChNum; n++) begin
            if (en_q) begin
                pwm_d[n] = (cnt_q < duty_act_q[n]) ^ pol_q[n];
            end
        end
        sync_d = en_q && (cnt_q == '0);
    end

    // Readback mux; PERIOD/DUTY return the shadow copies.
    always_comb begin
        rd_vld_d = blk_hit;
        rd_dat_d = '0;
        if (blk_hit) begin
            if (reg_off == 8'h00) begin
                rd_dat_d[0]             = en_q;
                rd_dat_d[1]             = mode_q;
                rd_dat_d[8 +: pChNum]   = pol_q;
            end
            if (reg_off == 8'h04) begin
                rd_dat_d[pCntWidth-1:0] = per_sh_q;
            end
            for (int n = 0; n < pChNum; n++) begin
                if (reg_off == 8'(8 + 4 * n)) begin
                    rd_dat_d[pCntWidth-1:0] = duty_sh_q[n];
                end
            end
            if (reg_off == 8'h40) begin
                rd_dat_d[pCntWidth-1:0] = cnt_q;
                rd_dat_d[31]            = dir_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            en_q      <= 1'b0;
            mode_q    <= 1'b0;
            pol_q     <= '0;
            per_sh_q  <= '0;
            per_act_q <= '0;
            for (int n = 0; n < pChNum; n++) begin
                duty_sh_q[n]  <= '0;
                duty_act_q[n] <= '0;
            end
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            pwm_q     <= '0;
            sync_q    <= 1'b0;
            rd_dat_q  <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            for (int n = 0; n < pChNum; n++) begin
                duty_sh_q[n]  <= duty_sh_d[n];
                duty_act_q[n] <= duty_act_d[n];
            end
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pwm_q     <= pwm_d;
            sync_q    <= sync_d;
            rd_dat_q  <= rd_dat_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign oPwm     = pwm_q;
    assign oPwmSync = sync_q;
    assign oSUsiRd  = rd_dat_q;
    assign oSUsiVd  = rd_vld_q;

endmodule

// File: doc/pwm_multi_channel_block.md
# pwm_multi_channel_block

Parametrised multi-channel PWM generator on the USI slave bus, the successor to the single-channel PWM block. It drives `pChNum` PWM outputs from one shared period counter. Each channel has its own duty and polarity. Period and duty writes are double-buffered so they take effect only at a period boundary, and an optional center-aligned (up/down) counting mode is provided. It sits in the processor peripheral space next to the other USI slave blocks and drives LED, backlight and buzzer pins.

## Interface
- `pBlockAdrsMap`, 8: LSB index of the block-select field in `iSUsiAdrs`.
- `pAdrsMap`, 2: block-select value; with the defaults the block decodes 0x02xx.
- `pBusAdrsBit`, 15: MSB index of the block-select field.
- `pChNum`, 4: number of PWM channels, 1–8.
- `pCntWidth`, 16: width of the counter, PERIOD and DUTY registers, 2–32.
- `iSysClk`  in  1  system clock; the only clock in the block.
- `iSysRst`  in  1  reset, synchronous, active-high.
- `iSUsiWd`  in  32  write data.
- `iSUsiAdrs`  in  16  register address.
- `iSUsiWCke`  in  1  write strobe, 1 cycle.
- `oSUsiRd`  out  32  read data.
- `oSUsiVd`  out  1  read data valid.
- `oPwm`  out  pChNum  PWM outputs, registered.
- `oPwmSync`  out  1  1-cycle pulse at each period boundary.

## Operation
- Block hit: `iSUsiAdrs[pBusAdrsBit:pBlockAdrsMap] == pAdrsMap`. The low byte is the register offset.
- Register map:
  - 0x00 CTRL: bit0 EN; bit1 MODE (0 = edge-aligned, 1 = center-aligned); bits[8+pChNum-1:8] POL per channel (1 = invert output).
  - 0x04 PERIOD.
  - 0x08 + 4·n DUTY[n], for n < pChNum.
  - 0x40 STATUS, read-only: bits[pCntWidth-1:0] current counter, bit31 count direction (1 = down).
  - Writes to unmapped offsets are ignored. Reads of unmapped offsets return 0.
- Write handling:
  - A write occurs when `iSUsiWCke` = 1 and the address hits the block. Only `iSUsiWd[pCntWidth-1:0]` is used for PERIOD and DUTY.
  - CTRL is applied immediately.
  - PERIOD and DUTY are written into shadow registers.
  - Shadow-to-active copy happens on the cycle `oPwmSync` fires, or on every cycle while EN = 0.
- Edge mode:
  - The counter counts 0..PERIOD, then wraps to 0. Period length is PERIOD+1 cycles.
  - `oPwmSync` pulses on the cycle the counter is 0.
- Center mode:
  - The counter counts up 0..PERIOD, then down PERIOD-1..1, then repeats. Period length is 2·PERIOD cycles.
  - `oPwmSync` pulses when the counter is 0.
  - With PERIOD = 0 the counter holds at 0 and `oPwmSync` pulses every cycle.
- Compare, per channel: raw[n] = (counter < DUTY_active[n]); oPwm[n] = raw[n] XOR POL[n].
  - DUTY = 0 gives a constant inactive level.
  - DUTY > PERIOD gives a constant active level in edge mode.
  - Comparison is unsigned over the full `pCntWidth`, with no wrap.
- EN = 0:
  - Counter is held at 0, direction is up, and `oPwmSync` = 0.
  - oPwm[n] = POL[n], the inactive level.
- EN 0→1: counting starts at 0 using the active values copied while disabled.
- Changing MODE while EN = 1 restarts the counter at 0, upward.
- Read path: `oSUsiVd` = registered block hit. `oSUsiRd` = registered readback of the addressed register. DUTY and PERIOD reads return the shadow value. Both are 0 when there is no hit.

## Timing
- Reset state:
  - All registers, the counter and direction are 0.
  - `oPwm` = 0, `oPwmSync` = 0, `oSUsiRd` = 0, `oSUsiVd` = 0.
- `iSysRst` asserted mid-operation returns the block to the reset state on the next edge. Outputs go to 0, overriding POL.
- CSR write: the register updates at the edge where `iSUsiWCke` is sampled high.
- Read latency: 1 cycle from address to `oSUsiRd`/`oSUsiVd`.
- Output latency: `oPwm` and `oPwmSync` are registered, 1 cycle behind the counter value that produced them.
- EN write edge to first counter value 0 with EN active: 1 cycle.
- Simultaneous events:
  - A DUTY or PERIOD write in the same cycle as the boundary copy: the shadow takes the new value; the active register receives the old shadow. The new value applies from the next boundary.
  - The CTRL.EN=0 write cycle takes priority over counting.

## Test plan
- Edge duty: PERIOD = 99, DUTY0 = 5, CTRL = 0x1 → `oPwm[0]` high for 5 cycles and low for 95; `oPwmSync` every 100 cycles.
- Center duty: PERIOD = 10, DUTY1 = 4, CTRL = 0x3 → `oPwm[1]` high for 7 cycles out of every 20 (counter values 3,2,1,0,1,2,3), symmetric about the counter-0 cycle.
- Double buffering: running with PERIOD = 99, DUTY0 = 5; write DUTY0 = 50 mid-period → the current period stays 5 high; the next period is 50 high, starting at the `oPwmSync` cycle.
- Limits and polarity: DUTY2 = 0, DUTY3 = 200, PERIOD = 99, POL = 0b0100 → `oPwm[2]` constant 1, `oPwm[3]` constant 1, others per duty; with EN = 0 the outputs equal POL.
- Readback and decode: write 0x1234 to 0x0204, read 0x0204 → `oSUsiRd` = 0x1234, `oSUsiVd` = 1 one cycle later; write to 0x0304 → no change and `oSUsiVd` = 0.
- Reset mid-run: assert `iSysRst` for 1 cycle during a high phase → all outputs 0 the next cycle; readback of all registers is 0.
